// File: rtl/md_sched.sv
// md_sched: sequencing controller for the E-stage multiply/divide unit.
// Accepts compute and move-to-HI/LO commands, runs a fixed-latency busy
// countdown for the hazard unit and commits results into HI/LO on completion.
// Optional feature macro: MD_MADD_EN (enables madd/maddu/msub/msubu, cop 5..8).
module md_sched #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  cop,
  input  logic [1:0]  wop,
  input  logic        rop,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        Req,
  output logic [31:0] date,
  output logic        busy,
  output logic [3:0]  remain,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 4;

  localparam logic [RW-1:0] MUL_LAT_W = RW'(MUL_LAT);
  localparam logic [RW-1:0] DIV_LAT_W = RW'(DIV_LAT);

  localparam logic [CW-1:0] COP_MULT  = 4'd1;
  localparam logic [CW-1:0] COP_MULTU = 4'd2;
  localparam logic [CW-1:0] COP_DIV   = 4'd3;
  localparam logic [CW-1:0] COP_DIVU  = 4'd4;
`ifdef MD_MADD_EN
  localparam logic [CW-1:0] COP_MADD  = 4'd5;
  localparam logic [CW-1:0] COP_MADDU = 4'd6;
  localparam logic [CW-1:0] COP_MSUB  = 4'd7;
  localparam logic [CW-1:0] COP_MSUBU = 4'd8;
  localparam logic [CW-1:0] COP_MAX   = COP_MSUBU;
`else
  localparam logic [CW-1:0] COP_MAX   = COP_DIVU;
`endif

  localparam logic [1:0] WOP_MTHI = 2'd1;
  localparam logic [1:0] WOP_MTLO = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   remain_q, remain_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cop_q, cop_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;

  logic            cop_ok_c;
  logic            is_mul_c;
  logic            mul_signed_c;
  logic [2*DW-1:0] mul_a_c;
  logic [2*DW-1:0] mul_b_c;
  logic [2*DW-1:0] prod_c;
  logic            div_signed_c;
  logic            a_neg_c;
  logic            b_neg_c;
  logic [DW-1:0]   a_mag_c;
  logic [DW-1:0]   b_mag_c;
  logic [DW-1:0]   q_mag_c;
  logic [DW-1:0]   r_mag_c;
  logic [DW-1:0]   quo_c;
  logic [DW-1:0]   rem_c;
  logic [2*DW-1:0] res_c;
  logic            commit_en_c;

  // Decode the incoming command: legality and latency class.
  always_comb begin
    cop_ok_c = (cop >= COP_MULT) && (cop <= COP_MAX);
    is_mul_c = (cop == COP_MULT) || (cop == COP_MULTU) || (cop > COP_DIVU);
  end

  // Shared 64-bit multiplier on the latched operands; signedness by sign extension.
  always_comb begin
    mul_signed_c = (cop_q == COP_MULT);
`ifdef MD_MADD_EN
    mul_signed_c = mul_signed_c || (cop_q == COP_MADD) || (cop_q == COP_MSUB);
`endif
    mul_a_c = {{DW{mul_signed_c & a_q[DW-1]}}, a_q};
    mul_b_c = {{DW{mul_signed_c & b_q[DW-1]}}, b_q};
    prod_c  = mul_a_c * mul_b_c;
  end

  // Single unsigned divider on magnitudes; signs restored afterwards so the
  // quotient truncates toward zero and 0x80000000 / -1 wraps to 0x80000000.
  always_comb begin
    div_signed_c = (cop_q == COP_DIV);
    a_neg_c      = div_signed_c & a_q[DW-1];
    b_neg_c      = div_signed_c & b_q[DW-1];
    a_mag_c      = a_neg_c ? DW'(-a_q) : a_q;
    b_mag_c      = b_neg_c ? DW'(-b_q) : b_q;
    if (b_mag_c == '0) begin
      q_mag_c = '0;
      r_mag_c = '0;
    end else begin
      q_mag_c = a_mag_c / b_mag_c;
      r_mag_c = a_mag_c % b_mag_c;
    end
    quo_c = (a_neg_c ^ b_neg_c) ? DW'(-q_mag_c) : q_mag_c;
    rem_c = a_neg_c ? DW'(-r_mag_c) : r_mag_c;
  end

  // Select the {hi,lo} value written at commit; divide by zero leaves HI/LO alone.
  always_comb begin
    res_c       = {hi_q, lo_q};
    commit_en_c = 1'b1;
    case (cop_q)
      COP_MULT, COP_MULTU: res_c = prod_c;
      COP_DIV, COP_DIVU: begin
        res_c       = {rem_c, quo_c};
        commit_en_c = (b_q != '0);
      end
`ifdef MD_MADD_EN
      COP_MADD, COP_MADDU: res_c = {hi_q, lo_q} + prod_c;
      COP_MSUB, COP_MSUBU: res_c = {hi_q, lo_q} - prod_c;
`endif
      default: commit_en_c = 1'b0;
    endcase
  end

  // Next-state and register updates for the IDLE/RUN sequencer.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    busy_d   = busy_q;
    cop_d    = cop_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !Req) begin
          if (cop_ok_c) begin
            state_d  = RUN;
            busy_d   = 1'b1;
            remain_d = is_mul_c ? MUL_LAT_W : DIV_LAT_W;
            cop_d    = cop;
            a_d      = in1;
            b_d      = in2;
          end else if (wop == WOP_MTHI) begin
            hi_d = in1;
          end else if (wop == WOP_MTLO) begin
            lo_d = in1;
          end
        end
      end
      RUN: begin
        remain_d = remain_q - 4'd1;
        if (remain_q <= 4'd1) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          remain_d = '0;
          if (commit_en_c) begin
            hi_d = res_c[2*DW-1:DW];
            lo_d = res_c[DW-1:0];
          end
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        remain_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      remain_q <= '0;
      busy_q   <= 1'b0;
      cop_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      cop_q    <= cop_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign date   = rop ? lo_q : hi_q;
  assign busy   = busy_q;
  assign remain = remain_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and random stimulus for md_sched, checked every cycle
// against a behavioural HI/LO model plus literal expectations.
module tb_md_sched;

  localparam int unsigned MUL = 5;
  localparam int unsigned DIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cop = '0;
  logic [1:0]  wop = '0;
  logic        rop = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        Req = 1'b0;
  logic [31:0] date;
  logic        busy;
  logic [3:0]  remain;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  md_sched #(.MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .cop(cop), .wop(wop), .rop(rop),
    .in1(in1), .in2(in2), .Req(Req), .date(date), .busy(busy),
    .remain(remain), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic [3:0]  m_cop = '0;

`ifdef MD_MADD_EN
  localparam int MAXC = 8;
`else
  localparam int MAXC = 4;
`endif

  task model_commit();
    longint      sa, sb;
    logic [63:0] sp, up;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    sp = 64'(sa * sb);
    up = {32'h0, m_a} * {32'h0, m_b};
    case (m_cop)
      4'd1: {m_hi, m_lo} = sp;
      4'd2: {m_hi, m_lo} = up;
      4'd3: if (m_b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      4'd4: if (m_b != 0) begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
      4'd5: {m_hi, m_lo} = {m_hi, m_lo} + sp;
      4'd6: {m_hi, m_lo} = {m_hi, m_lo} + up;
      4'd7: {m_hi, m_lo} = {m_hi, m_lo} - sp;
      4'd8: {m_hi, m_lo} = {m_hi, m_lo} - up;
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem = 0; m_hi = '0; m_lo = '0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) model_commit();
    end else if (start && !Req) begin
      if (int'(cop) >= 1 && int'(cop) <= MAXC) begin
        m_rem = (cop == 4'd3 || cop == 4'd4) ? DIV : MUL;
        m_cop = cop; m_a = in1; m_b = in2;
      end else if (wop == 2'd1) m_hi = in1;
      else if (wop == 2'd2) m_lo = in1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_rem != 0));
    chk("remain", 32'(remain), 32'(m_rem));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("date", date, rop ? m_lo : m_hi);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cmd(input logic [3:0] c, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] b, input logic r);
    @(posedge clk); #1;
    start = 1'b1; cop = c; wop = w; in1 = a; in2 = b; Req = r;
    @(posedge clk); #1;
    start = 1'b0; cop = '0; wop = '0; Req = 1'b0; in1 = $urandom; in2 = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 40) chk("idle_timeout", 32'(n), 32'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // reset while an operation is in flight
    cmd(4'd1, 2'd0, 32'd3, 32'd4, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; #1;
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_remain", 32'(remain), 32'h0);
    chk("rmid_hi", hi, 32'h0);
    chk("rmid_lo", lo, 32'h0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rmid_nocommit", lo, 32'h0);

    // mult / multu
    cmd(4'd1, 2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n);
    chk("mult_busy_len", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    cmd(4'd2, 2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div / divu by zero
    cmd(4'd3, 2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(n);
    chk("div_busy_len", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    cmd(4'd4, 2'd0, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    chk("divz_busy_len", 32'(n), 32'd10);
    chk("divz_lo", lo, 32'hFFFF_FFFD);
    chk("divz_hi", hi, 32'hFFFF_FFFF);

    // overflow divide
    cmd(4'd3, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    chk("dovf_lo", lo, 32'h8000_0000);
    chk("dovf_hi", hi, 32'h0);

    // moves and Req suppression
    cmd(4'd0, 2'd1, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", 32'(busy), 32'h0);
    cmd(4'd0, 2'd1, 32'hDEAD_BEEF, 32'd0, 1'b1);
    chk("mthi_req_hi", hi, 32'h1234_5678);
    cmd(4'd1, 2'd0, 32'd5, 32'd6, 1'b1);
    wait_idle(n);
    chk("mult_req_busy", 32'(n), 32'd0);

    // command during RUN ignored, Req during RUN does not cancel
    cmd(4'd3, 2'd0, 32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("run_remain6", 32'(remain), 32'd6);
    start = 1'b1; cop = 4'd3; in1 = 32'd9; in2 = 32'd1;
    @(posedge clk); #1; start = 1'b0; cop = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("run_remain3", 32'(remain), 32'd3);
    Req = 1'b1;
    @(posedge clk); #1; Req = 1'b0;
    wait_idle(n);
    chk("run_lo", lo, 32'd14);
    chk("run_hi", hi, 32'd2);

    // accumulate family
    cmd(4'd0, 2'd1, 32'h0, 32'd0, 1'b0);
    cmd(4'd0, 2'd2, 32'hFFFF_FFFF, 32'd0, 1'b0);
    cmd(4'd6, 2'd0, 32'd1, 32'd1, 1'b0);
    wait_idle(n);
`ifdef MD_MADD_EN
    chk("maddu_len", 32'(n), 32'd5);
    chk("maddu_hi", hi, 32'h1);
    chk("maddu_lo", lo, 32'h0);
`else
    chk("maddu_off_len", 32'(n), 32'd0);
    chk("maddu_off_hi", hi, 32'h0);
    chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    // random traffic, including commands presented while running
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom % 4) != 0;
      cop   = (($urandom % 8) < 6) ? 4'(1 + $urandom % 8) : 4'($urandom % 16);
      wop   = 2'($urandom % 4);
      rop   = 1'($urandom % 2);
      Req   = ($urandom % 6) == 0;
      in1   = pick();
      in2   = pick();
    end
    @(posedge clk); #1;
    start = 1'b0; Req = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the E-stage multiply/divide resource.
- Accepts mult/div/move-to-HI/LO commands from the E-stage decoder and runs a fixed-latency busy countdown for the hazard unit.
- Commits results to the architectural HI/LO registers on completion.
- Suppresses command side effects when the M stage raises an exception request (Req).

Parameters:
- MUL_LAT, 5, busy cycles for mult/multu (and madd family when enabled); legal 1..15
- DIV_LAT, 10, busy cycles for div/divu; legal 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command valid this cycle (E stage holds an MD instruction)
- cop  in  4  compute op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu
- wop  in  2  write op: 0 none, 1 mthi, 2 mtlo
- rop  in  1  read select: 0 HI, 1 LO
- in1  in  32  rs operand
- in2  in  32  rt operand
- Req  in  1  M-stage exception/interrupt flush
- date  out  32  combinational HI (rop=0) or LO (rop=1)
- busy  out  1  operation in flight
- remain  out  4  remaining busy cycles, 0 when idle
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, remain=0, state=IDLE; any in-flight result is discarded.
- States: IDLE, RUN.
- Compute command is accepted when state=IDLE, start=1, Req=0 and cop is in 1..4 (or 1..8 with the option enabled). On acceptance:
  - Latch in1/in2 and cop.
  - Next edge: state=RUN, busy=1, remain=LAT, where LAT = MUL_LAT for mult family and DIV_LAT for div family.
- RUN state:
  - remain decrements by 1 every cycle.
  - On the edge where remain goes 1->0: commit {hi,lo}, state=IDLE, busy=0.
  - Total busy window is exactly LAT cycles, starting the cycle after start.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 -> 64; same split.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned; lo=quotient, hi=remainder.
  - Divide by zero: full busy window still runs; hi/lo unchanged at commit.
  - div with 0x80000000/-1: lo=0x80000000, hi=0.
- Result computation is allowed to be combinational on the latched operands or iterative. Commit timing is fixed by the counter only.
- Write commands (wop != 0): accepted only when IDLE and Req=0. mthi sets hi=in1 and mtlo sets lo=in1 at the next edge; busy is not raised. When start=1 with a valid cop and wop!=0 in the same cycle, the compute command wins and wop is ignored.
- Commands arriving while RUN are ignored; the hazard unit stalls on start|busy and never presents them. Commands with Req=1 are ignored entirely: no latch, no busy, no hi/lo write.
- Req during RUN does not cancel the in-flight operation (its instruction has already retired past E); it completes and commits normally.
- date: combinational, reflects the committed hi/lo only. During RUN it returns the pre-operation values.
- Unused cop codes (9..15, or 5..8 when the option is off) are treated as none.

Optional Feature:
- Macro MD_MADD_EN.
- When defined: cop 5..8 are legal with MUL_LAT latency. At commit, {hi,lo} = {hi,lo} +/- product (64-bit, wrap-around), signed for madd/msub and unsigned for maddu/msubu. The base value is {hi,lo} sampled at commit.
- When undefined: cop 5..8 are ignored like none, and no accumulate datapath is synthesized.

Test Plan:
- Reset mid-RUN: start mult in1=3 in2=4, assert reset 2 cycles later -> immediately busy=0, remain=0, hi=lo=0, and no commit afterwards.
- mult in1=0xFFFFFFFF in2=2 -> busy=1 for exactly 5 cycles starting next cycle, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div in1=-7 in2=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu in1=7 in2=0 -> busy 10 cycles, hi/lo unchanged.
- mthi in1=0x12345678 with Req=0 -> hi=0x12345678 the next cycle, busy stays 0. Same command with Req=1 -> hi unchanged. start mult with Req=1 -> busy never asserts.
- start div while RUN (remain=6) -> ignored, and the first result commits on schedule. Req pulse at remain=3 -> the commit still occurs.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu in1=1 in2=1 -> after 5 cycles hi=1, lo=0. Without the macro the same command -> busy stays 0, hi/lo unchanged.
